cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
// Synthesizable run controller and debug tracer for the CPU core. It sequences the core reset,
// bounds execution to a programmable cycle budget, and records every change of the core's
// debug word into a timestamped trace FIFO. The FIFO is drained over a valid/ready port.
// It replaces the fixed 100 ns reset / 1M-cycle harness flow and works on silicon as well as in sim.
// PARAMETERS
// DATA_W      32  width of dbg_in and trace_data
// RST_CYCLES  10  cycles core_rst_n is held low after start (>=1)
// CNT_W       20  width of cycle counter, cycle_limit and trace_cycle
// DEPTH       16  trace FIFO entries (power of 2, >=2)
// PORTS
// clk          in   1       system clock, all logic on rising edge
// rst_n        in   1       synchronous active-low reset
// start        in   1       1-cycle pulse: begin a run (ignored unless IDLE or DONE)
// cycle_limit  in   CNT_W   run budget in cycles, sampled on start; 0 = unlimited
// core_rst_n   out  1       reset to the CPU core, active low
// dbg_in       in   DATA_W  CPU debug word (core's dbg_out)
// running      out  1       high in RUN state
// done         out  1       high in DONE state
// cycle_cnt    out  CNT_W   cycles elapsed in RUN, saturates at all-ones
// trace_valid  out  1       trace FIFO not empty
// trace_ready  in   1       consumer accepts the head entry when trace_valid=1
// trace_data   out  DATA_W  head entry: dbg_in value
// trace_cycle  out  CNT_W   head entry: cycle_cnt at capture
// overflow     out  1       sticky: a capture was dropped because the FIFO was full
// BEHAVIOUR
// - Reset (rst_n=0 at edge): state=IDLE, core_rst_n=0, running=0, done=0, cycle_cnt=0,
//   FIFO emptied (trace_valid=0), overflow=0, last-sample reg=0. Reset mid-run aborts immediately.
// - FSM: IDLE --start--> RST; RST --after RST_CYCLES cycles--> RUN;
//   RUN --(limit!=0 && cycle_cnt==limit-1)--> DONE; DONE --start--> RST.
// - start in RST/RUN is ignored.
// - Entry to RST from DONE: cycle_cnt, overflow and the last-sample reg are cleared;
//   the FIFO is NOT cleared.
// - core_rst_n=0 in IDLE and RST. It is 1 in RUN and DONE, so the core keeps running after DONE.
// - RST lasts exactly RST_CYCLES cycles: core_rst_n rises on the edge entering RUN.
// - cycle_cnt increments on every RUN cycle and reads 0 on the first RUN cycle.
//   With limit=N, RUN lasts exactly N cycles and cycle_cnt holds N-1 in DONE.
// - Unlimited runs saturate at 2^CNT_W-1; RUN is never left.
// - Capture happens only in RUN. On each RUN cycle, if dbg_in != last-sample reg, or it is the
//   first RUN cycle: push {dbg_in, cycle_cnt} and update last-sample reg. No captures in DONE.
// - FIFO is first-word fall-through. The head is visible on the cycle after the push; push->valid = 1 cycle.
//   A pop occurs when trace_valid && trace_ready. Outputs hold while valid && !ready.
// - Full FIFO with push and no pop: entry dropped, overflow set. Existing entries are untouched.
// - Full FIFO with push and pop in the same cycle: both happen, no overflow.
// - Empty FIFO with push: no pop, because valid was 0 that cycle.
// - Pointers are log2(DEPTH)+1 bits. Wrap-around is transparent; full/empty come from the MSB compare.
// TESTING
// 1 reset: rst_n low 10 cycles mid-RUN -> all outputs at reset values next edge; core_rst_n=0.
// 2 sequencing: start, limit=100, RST_CYCLES=10 -> core_rst_n=0 for 10 cycles, running for 100 cycles,
//   done with cycle_cnt=99, running=0.
// 3 capture: dbg_in=5 at RUN cycle 0, =5 at cycle 1, =7 at cycle 3 -> entries {5,0},{7,3} only.
// 4 overflow: ready=0, dbg_in changes every RUN cycle for 20 cycles, DEPTH=16 -> 16 entries cycles 0..15;
//   overflow=1; draining yields them in order.
// 5 full push+pop: FIFO full, ready=1 while dbg_in changes -> one pop and one push per cycle; count stays 16,
//   overflow=0.
// 6 unlimited/restart: limit=0 with CNT_W=8 -> cycle_cnt saturates at 255, done stays 0.
//   Separately, start in DONE -> cycle_cnt=0, FIFO contents kept.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run controller and debug tracer for the CPU core: sequences core reset, bounds execution to a
// cycle budget, and logs every change of the core's debug word into a first-word fall-through FIFO.
module cpu_run_ctrl #(
    parameter int DATA_W     = 32,
    parameter int RST_CYCLES = 10,
    parameter int CNT_W      = 20,
    parameter int DEPTH      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  cycle_limit,
    output logic              core_rst_n,
    input  logic [DATA_W-1:0] dbg_in,
    output logic              running,
    output logic              done,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [DATA_W-1:0] trace_data,
    output logic [CNT_W-1:0]  trace_cycle,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(RST_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  cyc;
    } entry_t;

    state_t            state, state_nxt;
    logic [RW-1:0]     rst_cnt;
    logic [CNT_W-1:0]  limit_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] last;
    logic [AW:0]       wr_ptr, rd_ptr;
    entry_t            mem [DEPTH];

    logic start_ok, rst_done, run_end;
    logic empty, full, push, pop, push_ok;

    assign start_ok = start && (state == S_IDLE || state == S_DONE);
    assign rst_done = (rst_cnt == RW'(RST_CYCLES - 1));
    assign run_end  = (limit_q != '0) && (cnt == limit_q - CNT_W'(1));

    // The first RUN cycle always captures; cnt is zero only then because it saturates, never wraps.
    assign push    = (state == S_RUN) && ((cnt == '0) || (dbg_in != last));
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && trace_ready;
    assign push_ok = push && (!full || pop);

    // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_RST;
            S_RST:   if (rst_done) state_nxt = S_RUN;
            S_RUN:   if (run_end)  state_nxt = S_DONE;
            S_DONE:  if (start_ok) state_nxt = S_RST;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_cnt  <= '0;
            limit_q  <= '0;
            cnt      <= '0;
            last     <= '0;
            overflow <= 1'b0;
        end else begin
            if (start_ok) begin
                rst_cnt  <= '0;
                limit_q  <= cycle_limit;
                cnt      <= '0;
                last     <= '0;
                overflow <= 1'b0;
            end else if (state == S_RST) begin
                rst_cnt <= rst_cnt + RW'(1);
            end else if (state == S_RUN && !run_end && cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (push) last <= dbg_in;
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: the storage array is not reset; emptiness is defined by the pointers, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= '{data: dbg_in, cyc: cnt};
    end

    assign core_rst_n  = (state == S_RUN) || (state == S_DONE);
    assign running     = (state == S_RUN);
    assign done        = (state == S_DONE);
    assign cycle_cnt   = cnt;
    assign trace_valid = !empty;
    assign trace_data  = mem[rd_ptr[AW-1:0]].data;
    assign trace_cycle = mem[rd_ptr[AW-1:0]].cyc;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: a phase/arithmetic reference model predicts outputs and trace
// entries; a separate monitor compares DUT outputs and pops expected entries as the consumer accepts them.
module tb_cpu_run_ctrl;

    localparam int DATA_W     = 32;
    localparam int RST_CYCLES = 10;
    localparam int CNT_W      = 8;
    localparam int DEPTH      = 16;
    localparam int MAXC       = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  cycle_limit = '0;
    logic              core_rst_n;
    logic [DATA_W-1:0] dbg_in = '0;
    logic              running, done;
    logic [CNT_W-1:0]  cycle_cnt;
    logic              trace_valid;
    logic              trace_ready = 1'b0;
    logic [DATA_W-1:0] trace_data;
    logic [CNT_W-1:0]  trace_cycle;
    logic              overflow;

    cpu_run_ctrl #(
        .DATA_W(DATA_W), .RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cycle_limit(cycle_limit),
        .core_rst_n(core_rst_n), .dbg_in(dbg_in), .running(running), .done(done),
        .cycle_cnt(cycle_cnt), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_data(trace_data), .trace_cycle(trace_cycle), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position in a run is just "edges since the accepted start".
    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } ent_t;

    ent_t              sb_q[$];
    bit                m_started = 0;
    int                m_k       = 0;
    int                m_limit   = 0;
    logic [DATA_W-1:0] m_last    = '0;
    bit                m_ovf     = 0;

    // 0 idle, 1 core held in reset, 2 running, 3 done
    function automatic int phase();
        int j;
        if (!m_started) return 0;
        if (m_k < RST_CYCLES) return 1;
        j = m_k - RST_CYCLES;
        if (m_limit != 0 && j >= m_limit) return 3;
        return 2;
    endfunction

    function automatic int exp_cnt();
        int ph;
        ph = phase();
        if (ph == 2) return (m_k - RST_CYCLES > MAXC) ? MAXC : m_k - RST_CYCLES;
        if (ph == 3) return m_limit - 1;
        return 0;
    endfunction

    task automatic step(input bit rn, input bit st, input int lim,
                        input logic [DATA_W-1:0] d, input bit rdy);
        int  ph, j, c;
        bit  pop_now;
        @(negedge clk);
        #1;
        rst_n = rn; start = st; cycle_limit = CNT_W'(lim); dbg_in = d; trace_ready = rdy;
        if (!rn) begin
            m_started = 0; m_k = 0; m_last = '0; m_ovf = 0;
            sb_q.delete();
        end else begin
            ph      = phase();
            pop_now = (sb_q.size() != 0) && rdy;
            if (ph == 2) begin
                j = m_k - RST_CYCLES;
                c = (j > MAXC) ? MAXC : j;
                if (j == 0 || d != m_last) begin
                    m_last = d;
                    if (sb_q.size() >= DEPTH && !pop_now) m_ovf = 1;
                    else sb_q.push_back('{data: d, cyc: c});
                end
            end
            if (st && (ph == 0 || ph == 3)) begin
                m_started = 1; m_k = 0; m_limit = lim; m_last = '0; m_ovf = 0;
            end else if (m_started) begin
                m_k++;
            end
        end
    endtask

    // Monitor: compares the DUT against the model after each edge, then retires accepted entries.
    initial begin
        forever begin
            @(negedge clk);
            check("core_rst_n",  core_rst_n,  phase() >= 2);
            check("running",     running,     phase() == 2);
            check("done",        done,        phase() == 3);
            check("cycle_cnt",   cycle_cnt,   exp_cnt());
            check("overflow",    overflow,    m_ovf);
            check("trace_valid", trace_valid, sb_q.size() != 0);
            if (trace_valid && sb_q.size() != 0) begin
                check("trace_data",  trace_data,  sb_q[0].data);
                check("trace_cycle", trace_cycle, sb_q[0].cyc);
            end
            #2;
            if (rst_n && trace_valid && trace_ready && sb_q.size() != 0) begin
                void'(sb_q.pop_front());
                pops++;
            end
        end
    end

    task automatic idle_steps(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1, 0, 0, '0, rdy);
    endtask

    initial begin
        int p0, lim, len;
        logic [DATA_W-1:0] d;

        repeat (3) step(0, 0, 0, '0, 0);
        idle_steps(3, 1);

        // Sequencing with limit=100 plus capture pattern 5,5,5,7,...; start mid-run is ignored.
        p0 = pops;
        step(1, 1, 100, '0, 1);
        idle_steps(RST_CYCLES, 1);
        for (int j = 0; j < 110; j++) begin
            d = (j < 3) ? 32'd5 : 32'd7;
            step(1, (j == 50), 3, d, 1);
        end
        idle_steps(2, 1);
        check("capture_entries", pops - p0, 2);
        check("done_cnt", cycle_cnt, 99);

        // Restart from DONE, unlimited, then reset mid-run for 10 cycles.
        step(1, 1, 0, '0, 1);
        idle_steps(RST_CYCLES, 1);
        for (int j = 0; j < 20; j++) step(1, 0, 0, $urandom_range(0, 3), $urandom_range(0, 1));
        repeat (10) step(0, 1, 5, 32'hdead, 1);
        idle_steps(2, 0);

        // Overflow: consumer stalled while dbg changes every cycle; run ends at 25 cycles.
        step(1, 1, 25, '0, 0);
        idle_steps(RST_CYCLES, 0);
        for (int j = 0; j < 30; j++) step(1, 0, 0, 32'h100 + j, 0);
        check("ovf_sticky", overflow, 1);

        // Restart from DONE keeps the full FIFO; push and pop every cycle without overflow.
        step(1, 1, 20, '0, 0);
        idle_steps(RST_CYCLES, 0);
        for (int j = 0; j < 24; j++) step(1, 0, 0, 32'h200 + j, 1);
        check("full_pushpop_ovf", overflow, 0);
        idle_steps(24, 1);

        // Unlimited run saturates the cycle counter.
        step(1, 1, 0, '0, 1);
        idle_steps(RST_CYCLES, 1);
        for (int j = 0; j < 300; j++) step(1, (j % 97) == 0, 7, $urandom_range(0, 3), $urandom_range(0, 3) != 0);
        check("saturated_cnt", cycle_cnt, MAXC);
        repeat (2) step(0, 0, 0, '0, 0);

        // Randomized runs: random limits, starts, readiness, debug activity and occasional reset.
        for (int r = 0; r < 12; r++) begin
            lim = $urandom_range(0, 40);
            len = RST_CYCLES + $urandom_range(5, 60);
            step(1, 1, lim, '0, $urandom_range(0, 1));
            for (int j = 0; j < len; j++)
                step(($urandom_range(0, 199) != 0), ($urandom_range(0, 15) == 0),
                     $urandom_range(1, 30), $urandom_range(0, 3), $urandom_range(0, 2) != 0);
        end

        idle_steps(DEPTH + 4, 1);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
